// File: rtl/tank_level_ctrl.sv
// Tank level controller.
// A raw 2-bit level code is debounced into an accepted level. A four-state
// FSM (IDLE / FILL / FULL / FAULT) runs the pump from that level and
// supervises fill time. The state, pump, alarm and a 7-segment level/fault
// glyph are driven only from registers.
//
// Handshake note: there is no valid/ready traffic on this block. Every input
// is sampled on every rising edge of clk_2. Every output is a pure decode of
// registered state, so no output can glitch with nivel or fault_clr.

module tank_level_ctrl #(
    parameter int DEBOUNCE     = 3,   // consecutive equal samples to accept a level (1..15)
    parameter int FILL_TIMEOUT = 20   // max cycles allowed in FILL (2..255)
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic [1:0] nivel,
    input  logic       fault_clr,
    output logic       pump,
    output logic       alarm,
    output logic [1:0] state,
    output logic [7:0] SEG
);

    // Level codes as delivered by the sensor.
    localparam logic [1:0] LVL_ALTO   = 2'b00;
    localparam logic [1:0] LVL_NORMAL = 2'b01;
    localparam logic [1:0] LVL_BAIXO  = 2'b10;
    localparam logic [1:0] LVL_DESCAL = 2'b11;

    // 7-segment glyphs.
    localparam logic [7:0] SEG_FAULT  = 8'h79;
    localparam logic [7:0] SEG_ALTO   = 8'h77;
    localparam logic [7:0] SEG_NORMAL = 8'h54;
    localparam logic [7:0] SEG_BAIXO  = 8'h7C;
    localparam logic [7:0] SEG_DESCAL = 8'h5E;

    localparam logic [3:0] DEB_N    = 4'(DEBOUNCE);
    localparam logic [7:0] TO_LAST  = 8'(FILL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_FULL  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    // Debouncer registers.
    logic [1:0] r_cand;
    logic [3:0] r_cnt;
    logic [1:0] r_lvl;

    // FSM registers.
    state_t     r_state;
    logic [7:0] r_timer;

    // FSM next-state values.
    state_t     w_state_nxt;
    logic [7:0] w_timer_nxt;

    // Debouncer: track a candidate and how long it has been stable; promote
    // it to the accepted level once it has been seen DEBOUNCE times in a row.
    // With DEBOUNCE==1 the first sample of a new code is already enough.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_cand <= LVL_NORMAL;
            r_cnt  <= DEB_N;
            r_lvl  <= LVL_NORMAL;
        end else if (nivel != r_cand) begin
            r_cand <= nivel;
            r_cnt  <= 4'd1;
            if (DEB_N == 4'd1) begin
                r_lvl <= nivel;
            end
        end else if (r_cnt < DEB_N) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt + 4'd1 == DEB_N) begin
                r_lvl <= r_cand;
            end
        end
    end

    // FSM state and fill timer register; reset overrides every transition.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_timer <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // FSM next-state logic. Uses r_lvl as it stood before the edge, so a
    // level accepted on this edge is acted on one edge later. The timer is
    // zero everywhere except while remaining in FILL.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = 8'd0;
        case (r_state)
            ST_IDLE: begin
                if (r_lvl == LVL_DESCAL) begin
                    w_state_nxt = ST_FAULT;
                end else if (r_lvl == LVL_BAIXO) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (r_lvl == LVL_DESCAL) begin
                    w_state_nxt = ST_FAULT;
                end else if (r_lvl == LVL_ALTO) begin
                    w_state_nxt = ST_FULL;
                end else if (r_timer == TO_LAST) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_state_nxt = ST_FILL;
                    w_timer_nxt = r_timer + 8'd1;
                end
            end
            ST_FULL: begin
                if (r_lvl == LVL_DESCAL) begin
                    w_state_nxt = ST_FAULT;
                end else if (r_lvl != LVL_ALTO) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FAULT: begin
                // Acknowledge only counts once the sensor is sane again.
                if (fault_clr && (r_lvl != LVL_DESCAL)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from registers only.
    always_comb begin
        pump  = (r_state == ST_FILL);
        alarm = (r_state == ST_FAULT);
        state = r_state;
        SEG   = SEG_NORMAL;
        if (r_state == ST_FAULT) begin
            SEG = SEG_FAULT;
        end else begin
            case (r_lvl)
                LVL_ALTO:   SEG = SEG_ALTO;
                LVL_NORMAL: SEG = SEG_NORMAL;
                LVL_BAIXO:  SEG = SEG_BAIXO;
                default:    SEG = SEG_DESCAL;
            endcase
        end
    end

endmodule

// File: tb/tb_tank_level_ctrl.sv
// Bench for tank_level_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model built from the
// level-acceptance and state-transition rules.

module tb_tank_level_ctrl;

    localparam int DEB = 3;
    localparam int FT  = 20;

    logic       clk_2;
    logic       reset;
    logic [1:0] nivel;
    logic       fault_clr;
    logic       pump;
    logic       alarm;
    logic [1:0] state;
    logic [7:0] SEG;

    int n_total;
    int n_bad;

    // Reference model state.
    int         m_state;     // 0 idle, 1 fill, 2 full, 3 fault
    int         m_fill_cyc;  // edges spent in FILL since entry
    logic [1:0] m_lvl;
    logic [1:0] hist[$];     // most recent DEB samples

    tank_level_ctrl #(
        .DEBOUNCE(DEB),
        .FILL_TIMEOUT(FT)
    ) dut (
        .clk_2(clk_2),
        .reset(reset),
        .nivel(nivel),
        .fault_clr(fault_clr),
        .pump(pump),
        .alarm(alarm),
        .state(state),
        .SEG(SEG)
    );

    // Clock.
    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input int st, input logic [1:0] lvl);
        if (st == 3) return 8'h79;
        case (lvl)
            2'b00:   return 8'h77;
            2'b01:   return 8'h54;
            2'b10:   return 8'h7C;
            default: return 8'h5E;
        endcase
    endfunction

    // One clock edge of the reference model, using the inputs sampled there.
    task automatic model_edge(input logic rst, input logic [1:0] n, input logic fc);
        int  ns;
        bool_all_eq: begin end
        if (rst) begin
            m_state    = 0;
            m_fill_cyc = 0;
            m_lvl      = 2'b01;
            hist.delete();
            for (int i = 0; i < DEB; i++) hist.push_back(2'b01);
            return;
        end
        ns = m_state;
        case (m_state)
            0: if (m_lvl == 2'b11) ns = 3; else if (m_lvl == 2'b10) ns = 1;
            1: if (m_lvl == 2'b11) ns = 3;
               else if (m_lvl == 2'b00) ns = 2;
               else if (m_fill_cyc + 1 >= FT) ns = 3;
            2: if (m_lvl == 2'b11) ns = 3; else if (m_lvl != 2'b00) ns = 0;
            default: if (fc && m_lvl != 2'b11) ns = 0;
        endcase
        m_fill_cyc = (m_state == 1 && ns == 1) ? m_fill_cyc + 1 : 0;
        m_state = ns;
        // A level is accepted once the last DEB samples agree.
        hist.push_back(n);
        if (hist.size() > DEB) void'(hist.pop_front());
        begin
            bit same = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
            if (same) m_lvl = hist[0];
        end
    endtask

    // Driver: one edge, advance the model, then compare away from the edge.
    task automatic tick();
        @(posedge clk_2);
        model_edge(reset, nivel, fault_clr);
        #1;
        chk("state", {6'd0, state}, 8'(m_state));
        chk("pump",  {7'd0, pump},  {7'd0, m_state == 1});
        chk("alarm", {7'd0, alarm}, {7'd0, m_state == 3});
        chk("seg",   SEG,           seg_of(m_state, m_lvl));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Wait (bounded) until pump reaches a value; a timeout is a failed check.
    task automatic wait_pump(input logic v, input int bound);
        int n = 0;
        while (pump !== v && n < bound) begin
            tick();
            n++;
        end
        chk("wait_pump", {7'd0, pump}, {7'd0, v});
    endtask

    // Count edges spent with pump on, bounded.
    task automatic count_fill(output int n);
        n = 0;
        while (pump === 1'b1 && n < 3 * FT) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        n_total = 0;
        n_bad   = 0;
        reset = 1'b1;
        nivel = 2'b11;
        fault_clr = 1'b1;

        // Reset held two edges with a bad sensor and fault_clr asserted.
        tick();
        tick();
        chk("rst_state", {6'd0, state}, 8'h00);
        chk("rst_pump",  {7'd0, pump},  8'h00);
        chk("rst_alarm", {7'd0, alarm}, 8'h00);
        chk("rst_seg",   SEG,           8'h54);
        fault_clr = 1'b0;
        reset = 1'b0;
        // Three edges to accept 11, the FSM reacts on the next one.
        tick(); tick(); tick();
        chk("desc_not_yet", {6'd0, state}, 8'h00);
        tick();
        chk("desc_fault", {6'd0, state}, 8'h03);
        chk("desc_seg",   SEG,           8'h79);

        // 01 -> 10: glyph after k+2, pump after k+3; then 00 -> FULL.
        nivel = 2'b01;
        do_reset();
        nivel = 2'b10;
        tick(); tick(); tick();
        chk("baixo_seg",  SEG,          8'h7C);
        chk("baixo_pump0", {7'd0, pump}, 8'h00);
        tick();
        chk("baixo_pump1", {7'd0, pump}, 8'h01);
        nivel = 2'b00;
        repeat (4) tick();
        chk("full_state", {6'd0, state}, 8'h02);
        chk("full_pump",  {7'd0, pump},  8'h00);
        chk("full_seg",   SEG,           8'h77);

        // Short glitch is ignored.
        nivel = 2'b01;
        do_reset();
        nivel = 2'b10;
        tick(); tick();
        nivel = 2'b01;
        repeat (5) tick();
        chk("glitch_seg",  SEG,          8'h54);
        chk("glitch_pump", {7'd0, pump}, 8'h00);

        // Fill timeout, then acknowledge and re-enter FILL.
        nivel = 2'b10;
        wait_pump(1'b1, 10);
        count_fill(n);
        chk("fill_len",    8'(n),         8'(FT));
        chk("to_state",    {6'd0, state}, 8'h03);
        chk("to_alarm",    {7'd0, alarm}, 8'h01);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr_idle", {6'd0, state}, 8'h00);
        tick();
        chk("refill", {6'd0, state}, 8'h01);

        // Bad sensor in FILL; acknowledge is ignored until it recovers.
        nivel = 2'b11;
        repeat (4) tick();
        chk("fill_desc", {6'd0, state}, 8'h03);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr_ignored", {6'd0, state}, 8'h03);
        nivel = 2'b01;
        repeat (3) tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr_ok_state", {6'd0, state}, 8'h00);
        chk("clr_ok_seg",   SEG,           8'h54);

        // Reset mid-FILL drops the pump; the next FILL gets the full time.
        nivel = 2'b10;
        wait_pump(1'b1, 10);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        chk("midrst_pump", {7'd0, pump}, 8'h00);
        reset = 1'b0;
        wait_pump(1'b1, 10);
        count_fill(n);
        chk("refill_len", 8'(n), 8'(FT));

        // Randomized traffic: held runs of sensor codes, random acks, rare resets.
        for (int r = 0; r < 300; r++) begin
            nivel = 2'($urandom_range(0, 3));
            for (int h = $urandom_range(1, 6); h > 0; h--) begin
                fault_clr = ($urandom_range(0, 3) == 0);
                reset     = ($urandom_range(0, 59) == 0);
                tick();
            end
        end
        // Long low-level run to reach the fill timeout under random history.
        reset = 1'b0;
        fault_clr = 1'b0;
        nivel = 2'b10;
        repeat (2 * FT) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
